// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : handshaked, registered ALU; iterative shifts (and optional       |
// |           shift-add multiply when ALU_MUL_EN is defined).                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] c_op_add  = 3'b001;
  localparam logic [2:0] c_op_nand = 3'b010;
  localparam logic [2:0] c_op_cmp  = 3'b011;
  localparam logic [2:0] c_op_shl  = 3'b100;
  localparam logic [2:0] c_op_shr  = 3'b101;
  localparam logic [2:0] c_op_eq   = 3'b110;
  localparam logic [2:0] c_op_addr = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef ALU_MUL_EN
    , MUL = 2'd3
`endif
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;
  logic             r_shr, w_shr_nxt;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
`endif

  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shr;

  assign w_sum     = data1 + data2;
  assign w_add_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1] != data1[WIDTH-1]);
  assign w_shamt   = data2[SHW-1:0];
  assign w_is_shr  = (alu_op == c_op_shr);

  function automatic logic [WIDTH-1:0] f_shift1(input logic [WIDTH-1:0] v, input logic shr);
    return shr ? {v[WIDTH-1], v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

  // The accept edge already performs the first shift step, so a shift by N
  // finishes on the N-th edge counting the accept edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_cnt_nxt    = r_cnt;
    w_shr_nxt    = r_shr;
`ifdef ALU_MUL_EN
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_zero_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
          case (alu_op)
            c_op_add, c_op_addr: begin
              w_result_nxt = w_sum;
              w_ovf_nxt    = w_add_ovf;
            end
            c_op_nand: w_result_nxt = ~(data1 & data2);
            c_op_cmp:  w_result_nxt = ($signed(data1) > $signed(data2)) ? '1 : '0;
            c_op_eq: begin
              w_result_nxt = '0;
              w_zero_nxt   = (data1 == data2);
            end
            c_op_shl, c_op_shr: begin
              w_shr_nxt = w_is_shr;
              if (w_shamt == '0) begin
                w_result_nxt = data1;
              end else begin
                w_result_nxt = f_shift1(data1, w_is_shr);
                w_cnt_nxt    = w_shamt - SHW'(1);
                if (w_shamt != SHW'(1)) w_state_nxt = SHIFT;
              end
            end
            default: begin
`ifdef ALU_MUL_EN
              // Accept edge consumes multiplier bit 0; WIDTH-1 bits remain.
              w_result_nxt = data2[0] ? data1 : '0;
              w_mcand_nxt  = data1 << 1;
              w_mplier_nxt = data2 >> 1;
              w_cnt_nxt    = SHW'(WIDTH - 1);
              w_state_nxt  = MUL;
`else
              w_result_nxt = '0;
`endif
            end
          endcase
        end
      end
      SHIFT: begin
        w_result_nxt = f_shift1(r_result, r_shr);
        w_cnt_nxt    = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) w_state_nxt = DONE;
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (r_mplier[0]) w_result_nxt = r_result + r_mcand;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) w_state_nxt = DONE;
      end
`endif
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_shr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shr    <= w_shr_nxt;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
    end
  end
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
